// File: rtl/cp0_timer_intc.sv
// CP0 register file with a prescaled Count/Compare timer and interrupt request.
// Define CP0_HW_INT_SYNC_EN to put a 2-flop synchroniser on hw_int_i.
module cp0_timer_intc #(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_slot_i,
  input  logic [31:0]           badvaddr_i,
  input  logic                  eret_i,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  output logic                  int_req_o,
  output logic                  timer_int_o,
  output logic [31:0]           epc_o,
  output logic                  exl_o,
  output logic [31:0]           exc_vector_o
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [31:0]           badvaddr;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [31:0]           epc;
  logic [7:0]            im;
  logic                  exl;
  logic                  ie;
  logic                  bd;
  logic                  timer_pending;
  logic [1:0]            sw_ip;
  logic [4:0]            exc_code;
  logic [DW-1:0]         div;
  logic [HW_INT_NUM-1:0] hw_s;
  logic [5:0]            hw_ext;
  logic [7:0]            ip;

  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic cnt_tick;
  logic cnt_hit;
  logic bad_addr;

  assign wr_count   = we & (addr == 5'd9);
  assign wr_compare = we & (addr == 5'd11);
  assign wr_status  = we & (addr == 5'd12);
  assign wr_cause   = we & (addr == 5'd13);
  assign wr_epc     = we & (addr == 5'd14);

`ifdef CP0_HW_INT_SYNC_EN
  logic [HW_INT_NUM-1:0] hw_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_meta <= '0;
      hw_s    <= '0;
    end else begin
      hw_meta <= hw_int_i;
      hw_s    <= hw_meta;
    end
  end
`else
  assign hw_s = hw_int_i;
`endif

  // Line 5 shares IP7 with the timer; absent lines read as 0.
  assign hw_ext = 6'(hw_s);
  assign ip = {timer_pending | hw_ext[5], hw_ext[4:0], sw_ip};

  assign cnt_tick = (div == DIV_LAST);
  assign cnt_hit  = cnt_tick & ~wr_count &
                    ((count + 32'd1) == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      div   <= '0;
    end else if (wr_count) begin
      count <= wdata;
      div   <= '0;
    end else if (cnt_tick) begin
      count <= count + 32'd1;
      div   <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare       <= 32'hFFFFFFFF;
      timer_pending <= 1'b0;
    end else begin
      if (wr_compare) compare <= wdata;
      if (wr_compare) timer_pending <= 1'b0;
      else if (cnt_hit) timer_pending <= 1'b1;
    end
  end

  assign bad_addr = (exc_code_i == 5'h04) | (exc_code_i == 5'h05);

  // Exception entry overrides MTC0/ERET for EXL, EPC and Cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr <= '0;
      epc      <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      sw_ip    <= '0;
      exc_code <= '0;
    end else begin
      if (wr_status) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (exc_valid_i) begin
        exc_code <= exc_code_i;
        if (!exl) begin
          epc <= in_delay_slot_i ? pc_i - 32'd4 : pc_i;
          bd  <= in_delay_slot_i;
          exl <= 1'b1;
          if (bad_addr) badvaddr <= badvaddr_i;
        end
      end else begin
        if (eret_i) exl <= 1'b0;
        else if (wr_status) exl <= wdata[1];
        if (wr_cause) sw_ip <= wdata[9:8];
        if (wr_epc) epc <= wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_req_o <= 1'b0;
    else int_req_o <= ie & ~exl & (|(ip & im));
  end

  always_comb begin
    rdata = '0;
    case (addr)
      5'd8:    rdata = badvaddr;
      5'd9:    rdata = count;
      5'd11:   rdata = compare;
      5'd12:   rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      5'd13:   rdata = {bd, timer_pending, 14'b0, ip,
                        1'b0, exc_code, 2'b0};
      5'd14:   rdata = epc;
      default: rdata = '0;
    endcase
  end

  assign timer_int_o  = timer_pending;
  assign epc_o        = epc;
  assign exl_o        = exl;
  assign exc_vector_o = EXC_VECTOR;

endmodule
